// File: rtl/multicycle_control_unit_if.sv
// Control-unit bus: instruction fields and memory/ALU status in,
// datapath enables, selects and observability outputs back.
interface multicycle_control_unit_if #(
  parameter int CNT_W = 32
);
  logic [6:0]       Op;
  logic [2:0]       funct3;
  logic [6:0]       funct7;
  logic             Zero;
  logic             mem_ready;
  logic             PCWrite;
  logic             IRWrite;
  logic             RegWrite;
  logic             MemWrite;
  logic             AdrSrc;
  logic [1:0]       ResultSrc;
  logic [1:0]       ALUSrcA;
  logic [1:0]       ALUSrcB;
  logic [1:0]       ImmSrc;
  logic [2:0]       ALUControl;
  logic             illegal_op;
  logic [3:0]       state;
  logic [CNT_W-1:0] retired;

  // Datapath / environment side
  modport master (
    output Op, funct3, funct7, Zero, mem_ready,
    input  PCWrite, IRWrite, RegWrite, MemWrite, AdrSrc, ResultSrc,
           ALUSrcA, ALUSrcB, ImmSrc, ALUControl, illegal_op, state, retired
  );

  // Control unit side
  modport slave (
    input  Op, funct3, funct7, Zero, mem_ready,
    output PCWrite, IRWrite, RegWrite, MemWrite, AdrSrc, ResultSrc,
           ALUSrcA, ALUSrcB, ImmSrc, ALUControl, illegal_op, state, retired
  );
endinterface

// File: rtl/multicycle_control_unit.sv
// Multicycle RISC-V style control unit: Moore FSM sequencing the shared
// datapath, ALU decoder and a retired-instruction counter.
module multicycle_control_unit #(
  parameter int HS_EN = 1,
  parameter int CNT_W = 32
) (
  input  logic                         clk,
  input  logic                         rst,
  multicycle_control_unit_if.slave     bus
);

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECUTER = 4'd6,
    S_EXECUTEI = 4'd7,
    S_ALUWB    = 4'd8,
    S_BEQ      = 4'd9,
    S_JAL      = 4'd10
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] retired_q, retired_d;

  logic       ready_s;
  logic       pc_write_s, ir_write_s, reg_write_s, mem_write_s, adr_src_s;
  logic [1:0] result_src_s, alu_src_a_s, alu_src_b_s, imm_src_s, alu_op_s;
  logic [2:0] alu_ctrl_s;
  logic       illegal_s, retire_s;
  logic       unused_s;

  // With the handshake disabled every memory access completes in one cycle.
  assign ready_s  = (HS_EN != 0) ? bus.mem_ready : 1'b1;
  assign unused_s = ^{bus.funct7[6], bus.funct7[4:0]};

  // Next-state and Moore outputs; every output defaults to 0 / select 00.
  always_comb begin
    state_d      = S_FETCH;
    pc_write_s   = 1'b0;
    ir_write_s   = 1'b0;
    reg_write_s  = 1'b0;
    mem_write_s  = 1'b0;
    adr_src_s    = 1'b0;
    result_src_s = 2'b00;
    alu_src_a_s  = 2'b00;
    alu_src_b_s  = 2'b00;
    imm_src_s    = 2'b00;
    alu_op_s     = 2'b00;
    illegal_s    = 1'b0;
    retire_s     = 1'b0;
    case (state_q)
      S_FETCH: begin
        alu_src_b_s  = 2'b10;
        result_src_s = 2'b10;
        ir_write_s   = ready_s;
        pc_write_s   = ready_s;
        if (ready_s) state_d = S_DECODE;
        else         state_d = S_FETCH;
      end
      S_DECODE: begin
        alu_src_a_s = 2'b01;
        alu_src_b_s = 2'b01;
        imm_src_s   = 2'b10;
        case (bus.Op)
          7'b0000011, 7'b0100011: state_d = S_MEMADR;
          7'b0110011:             state_d = S_EXECUTER;
          7'b0010011:             state_d = S_EXECUTEI;
          7'b1100011:             state_d = S_BEQ;
          7'b1101111:             state_d = S_JAL;
          default: begin
            state_d   = S_FETCH;
            illegal_s = 1'b1;
          end
        endcase
      end
      S_MEMADR: begin
        alu_src_a_s = 2'b10;
        alu_src_b_s = 2'b01;
        // Op[5] separates stores (S-type immediate) from loads.
        if (bus.Op[5]) begin
          imm_src_s = 2'b01;
          state_d   = S_MEMWRITE;
        end else begin
          imm_src_s = 2'b00;
          state_d   = S_MEMREAD;
        end
      end
      S_MEMREAD: begin
        adr_src_s = 1'b1;
        if (ready_s) state_d = S_MEMWB;
        else         state_d = S_MEMREAD;
      end
      S_MEMWB: begin
        result_src_s = 2'b01;
        reg_write_s  = 1'b1;
        retire_s     = 1'b1;
        state_d      = S_FETCH;
      end
      S_MEMWRITE: begin
        adr_src_s   = 1'b1;
        mem_write_s = 1'b1;
        if (ready_s) begin
          retire_s = 1'b1;
          state_d  = S_FETCH;
        end else begin
          retire_s = 1'b0;
          state_d  = S_MEMWRITE;
        end
      end
      S_EXECUTER: begin
        alu_src_a_s = 2'b10;
        alu_op_s    = 2'b10;
        state_d     = S_ALUWB;
      end
      S_EXECUTEI: begin
        alu_src_a_s = 2'b10;
        alu_src_b_s = 2'b01;
        alu_op_s    = 2'b10;
        state_d     = S_ALUWB;
      end
      S_ALUWB: begin
        reg_write_s = 1'b1;
        retire_s    = 1'b1;
        state_d     = S_FETCH;
      end
      S_BEQ: begin
        alu_src_a_s = 2'b10;
        alu_op_s    = 2'b01;
        pc_write_s  = bus.Zero;
        retire_s    = 1'b1;
        state_d     = S_FETCH;
      end
      S_JAL: begin
        alu_src_a_s = 2'b01;
        alu_src_b_s = 2'b10;
        pc_write_s  = 1'b1;
        state_d     = S_ALUWB;
      end
      default: state_d = S_FETCH;
    endcase
  end

  // ALU decoder: ALUOp plus funct fields select the ALU operation.
  always_comb begin
    alu_ctrl_s = 3'b000;
    case (alu_op_s)
      2'b00: alu_ctrl_s = 3'b000;
      2'b01: alu_ctrl_s = 3'b001;
      2'b10: begin
        case (bus.funct3)
          3'b000: begin
            // Only register-register ops with funct7[5] subtract.
            if (bus.Op[5] & bus.funct7[5]) alu_ctrl_s = 3'b001;
            else                           alu_ctrl_s = 3'b000;
          end
          3'b010:  alu_ctrl_s = 3'b101;
          3'b110:  alu_ctrl_s = 3'b011;
          3'b111:  alu_ctrl_s = 3'b010;
          default: alu_ctrl_s = 3'b000;
        endcase
      end
      default: alu_ctrl_s = 3'b000;
    endcase
  end

  // Retired counter advances on every completing transition back to FETCH.
  always_comb begin
    if (retire_s) retired_d = retired_q + {{(CNT_W-1){1'b0}}, 1'b1};
    else          retired_d = retired_q;
  end

  // State and counter registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_FETCH;
      retired_q <= {CNT_W{1'b0}};
    end else begin
      state_q   <= state_d;
      retired_q <= retired_d;
    end
  end

  // Write enables and the illegal pulse are suppressed while reset is held.
  assign bus.PCWrite    = pc_write_s  & ~rst;
  assign bus.IRWrite    = ir_write_s  & ~rst;
  assign bus.RegWrite   = reg_write_s & ~rst;
  assign bus.MemWrite   = mem_write_s & ~rst;
  assign bus.illegal_op = illegal_s   & ~rst;
  assign bus.AdrSrc     = adr_src_s;
  assign bus.ResultSrc  = result_src_s;
  assign bus.ALUSrcA    = alu_src_a_s;
  assign bus.ALUSrcB    = alu_src_b_s;
  assign bus.ImmSrc     = imm_src_s;
  assign bus.ALUControl = alu_ctrl_s;
  assign bus.state      = state_q;
  assign bus.retired    = retired_q;

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Scoreboard bench for multicycle_control_unit: per-cycle expectations are
// queued as stimulus is planned and compared as the DUT steps through them.
module tb_multicycle_control_unit;
  localparam int CW = 4;

  logic clk = 1'b0;
  logic rst;
  logic rst2;
  always #5 clk = ~clk;

  multicycle_control_unit_if #(.CNT_W(CW)) bus ();
  multicycle_control_unit_if #(.CNT_W(32)) bus2 ();

  multicycle_control_unit #(.HS_EN(1), .CNT_W(CW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  multicycle_control_unit #(.HS_EN(0), .CNT_W(32)) dut_nohs (
    .clk (clk),
    .rst (rst2),
    .bus (bus2)
  );

  typedef struct packed {
    logic [3:0]    st;
    logic          rdy;
    logic [3:0]    en;   // {PCWrite, IRWrite, RegWrite, MemWrite}
    logic [2:0]    aluc;
    logic          ill;
    logic [CW-1:0] ret;
  } exp_t;

  exp_t          sb_q[$];
  int            total = 0;
  int            bad   = 0;
  logic [CW-1:0] exp_ret;

  // Select table {AdrSrc, ResultSrc, ALUSrcA, ALUSrcB, ImmSrc} per state.
  function automatic logic [8:0] sel_exp(input logic [3:0] st, input logic [6:0] op);
    case (st)
      4'd0:    return 9'b0_10_00_10_00;
      4'd1:    return 9'b0_00_01_01_10;
      4'd2:    return op[5] ? 9'b0_00_10_01_01 : 9'b0_00_10_01_00;
      4'd3:    return 9'b1_00_00_00_00;
      4'd4:    return 9'b0_01_00_00_00;
      4'd5:    return 9'b1_00_00_00_00;
      4'd6:    return 9'b0_00_10_00_00;
      4'd7:    return 9'b0_00_10_01_00;
      4'd8:    return 9'b0_00_00_00_00;
      4'd9:    return 9'b0_00_10_00_00;
      4'd10:   return 9'b0_00_01_10_00;
      default: return 9'b0_00_00_00_00;
    endcase
  endfunction

  task automatic push(input logic [3:0] st, input logic rdy, input logic [3:0] en,
                      input logic [2:0] aluc, input logic ill);
    sb_q.push_back(exp_t'{st, rdy, en, aluc, ill, exp_ret});
  endtask

  task automatic set_instr(input logic [6:0] op, input logic [2:0] f3,
                           input logic [6:0] f7, input logic zero);
    bus.Op = op; bus.funct3 = f3; bus.funct7 = f7; bus.Zero = zero;
  endtask

  task automatic push_fetch_decode();
    push(4'd0, 1'b1, 4'b1100, 3'b000, 1'b0);
    push(4'd1, 1'b1, 4'b0000, 3'b000, 1'b0);
  endtask

  // Pop one expectation per cycle, drive its mem_ready, compare mid-cycle.
  task automatic drain(input string name);
    exp_t       e;
    logic [3:0] act_en;
    logic [8:0] act_sel;
    logic [8:0] want_sel;
    while (sb_q.size() > 0) begin
      @(negedge clk);
      e = sb_q.pop_front();
      bus.mem_ready = e.rdy;
      #1;
      act_en = {bus.PCWrite, bus.IRWrite, bus.RegWrite, bus.MemWrite};
      total++;
      if (bus.state !== e.st || act_en !== e.en || bus.ALUControl !== e.aluc ||
          bus.illegal_op !== e.ill || bus.retired !== e.ret) begin
        bad++;
        $display("FAIL %s: got state=%0d en=%b aluc=%b ill=%b ret=%0d want state=%0d en=%b aluc=%b ill=%b ret=%0d",
                 name, bus.state, act_en, bus.ALUControl, bus.illegal_op, bus.retired,
                 e.st, e.en, e.aluc, e.ill, e.ret);
      end
      act_sel  = {bus.AdrSrc, bus.ResultSrc, bus.ALUSrcA, bus.ALUSrcB, bus.ImmSrc};
      want_sel = sel_exp(e.st, bus.Op);
      total++;
      if (act_sel !== want_sel) begin
        bad++;
        $display("FAIL %s_sel: state=%0d got=%b want=%b", name, e.st, act_sel, want_sel);
      end
    end
  endtask

  task automatic test_reset();
    logic [3:0] act_en;
    rst = 1'b1;
    bus.mem_ready = 1'b1;
    set_instr(7'b0110011, 3'b000, 7'b0000000, 1'b0);
    @(posedge clk);
    @(negedge clk);
    #1;
    act_en = {bus.PCWrite, bus.IRWrite, bus.RegWrite, bus.MemWrite};
    total++;
    if (bus.state !== 4'd0 || act_en !== 4'b0000 || bus.retired !== 4'd0 || bus.illegal_op !== 1'b0) begin
      bad++;
      $display("FAIL reset_hold: state=%0d en=%b ret=%0d ill=%b want 0 0000 0 0",
               bus.state, act_en, bus.retired, bus.illegal_op);
    end
    bus.mem_ready = 1'b0;
    rst = 1'b0;
    exp_ret = '0;
    push(4'd0, 1'b0, 4'b0000, 3'b000, 1'b0);
    drain("reset_release");
  endtask

  task automatic run_alu(input string name, input logic [6:0] op, input logic [2:0] f3,
                         input logic [6:0] f7, input logic [2:0] aluc);
    set_instr(op, f3, f7, 1'b0);
    push_fetch_decode();
    push((op == 7'b0110011) ? 4'd6 : 4'd7, 1'b1, 4'b0000, aluc, 1'b0);
    push(4'd8, 1'b1, 4'b0010, 3'b000, 1'b0);
    drain(name);
    exp_ret = exp_ret + 1'b1;
  endtask

  // Back-to-back register and immediate ALU instructions.
  task automatic test_alu();
    run_alu("r_add",  7'b0110011, 3'b000, 7'b0000000, 3'b000);
    run_alu("r_sub",  7'b0110011, 3'b000, 7'b0100000, 3'b001);
    run_alu("r_slt",  7'b0110011, 3'b010, 7'b0000000, 3'b101);
    run_alu("r_or",   7'b0110011, 3'b110, 7'b0000000, 3'b011);
    run_alu("r_and",  7'b0110011, 3'b111, 7'b0000000, 3'b010);
    run_alu("r_sll",  7'b0110011, 3'b001, 7'b0000000, 3'b000);
    run_alu("i_addi", 7'b0010011, 3'b000, 7'b0100000, 3'b000);
    run_alu("i_ori",  7'b0010011, 3'b110, 7'b0000000, 3'b011);
  endtask

  task automatic test_lw();
    set_instr(7'b0000011, 3'b010, 7'b0000000, 1'b0);
    push(4'd0, 1'b0, 4'b0000, 3'b000, 1'b0);
    push_fetch_decode();
    push(4'd2, 1'b1, 4'b0000, 3'b000, 1'b0);
    push(4'd3, 1'b0, 4'b0000, 3'b000, 1'b0);
    push(4'd3, 1'b1, 4'b0000, 3'b000, 1'b0);
    push(4'd4, 1'b1, 4'b0010, 3'b000, 1'b0);
    drain("lw");
    exp_ret = exp_ret + 1'b1;
  endtask

  task automatic test_sw();
    set_instr(7'b0100011, 3'b010, 7'b0000000, 1'b0);
    push_fetch_decode();
    push(4'd2, 1'b1, 4'b0000, 3'b000, 1'b0);
    for (int i = 0; i < 3; i++) push(4'd5, 1'b0, 4'b0001, 3'b000, 1'b0);
    push(4'd5, 1'b1, 4'b0001, 3'b000, 1'b0);
    drain("sw");
    exp_ret = exp_ret + 1'b1;
  endtask

  task automatic test_beq();
    set_instr(7'b1100011, 3'b000, 7'b0000000, 1'b1);
    push_fetch_decode();
    push(4'd9, 1'b1, 4'b1000, 3'b001, 1'b0);
    drain("beq_taken");
    exp_ret = exp_ret + 1'b1;
    set_instr(7'b1100011, 3'b000, 7'b0000000, 1'b0);
    push_fetch_decode();
    push(4'd9, 1'b1, 4'b0000, 3'b001, 1'b0);
    drain("beq_not_taken");
    exp_ret = exp_ret + 1'b1;
  endtask

  task automatic test_jal();
    set_instr(7'b1101111, 3'b000, 7'b0000000, 1'b0);
    push_fetch_decode();
    push(4'd10, 1'b1, 4'b1000, 3'b000, 1'b0);
    push(4'd8, 1'b1, 4'b0010, 3'b000, 1'b0);
    drain("jal");
    exp_ret = exp_ret + 1'b1;
  endtask

  task automatic test_illegal();
    set_instr(7'b1111111, 3'b000, 7'b0000000, 1'b0);
    push_fetch_decode();
    sb_q[sb_q.size()-1].ill = 1'b1;
    push(4'd0, 1'b0, 4'b0000, 3'b000, 1'b0);
    drain("illegal");
  endtask

  // Sixteen branches walk the 4-bit counter through its wrap.
  task automatic test_wrap();
    set_instr(7'b1100011, 3'b000, 7'b0000000, 1'b0);
    for (int k = 0; k < 16; k++) begin
      push_fetch_decode();
      push(4'd9, 1'b1, 4'b0000, 3'b001, 1'b0);
      drain("wrap");
      exp_ret = exp_ret + 1'b1;
    end
    push(4'd0, 1'b0, 4'b0000, 3'b000, 1'b0);
    drain("wrap_end");
  endtask

  task automatic test_reset_mid_write();
    set_instr(7'b0100011, 3'b010, 7'b0000000, 1'b0);
    push_fetch_decode();
    push(4'd2, 1'b1, 4'b0000, 3'b000, 1'b0);
    push(4'd5, 1'b0, 4'b0001, 3'b000, 1'b0);
    drain("rst_sw_pre");
    @(negedge clk);
    rst = 1'b1;
    bus.mem_ready = 1'b0;
    #1;
    total++;
    if (bus.MemWrite !== 1'b0 || bus.state !== 4'd5) begin
      bad++;
      $display("FAIL rst_mid_write: MemWrite=%b state=%0d want 0 5", bus.MemWrite, bus.state);
    end
    @(negedge clk);
    #1;
    total++;
    if (bus.state !== 4'd0 || bus.retired !== 4'd0) begin
      bad++;
      $display("FAIL rst_mid_write_after: state=%0d ret=%0d want 0 0", bus.state, bus.retired);
    end
    rst = 1'b0;
    exp_ret = '0;
    push(4'd0, 1'b0, 4'b0000, 3'b000, 1'b0);
    drain("rst_mid_write_release");
  endtask

  task automatic hs0_step(input string name, input logic [3:0] st);
    #1;
    total++;
    if (bus2.state !== st) begin
      bad++;
      $display("FAIL %s: state=%0d want %0d", name, bus2.state, st);
    end
    @(negedge clk);
  endtask

  // Handshake disabled: mem_ready held low is ignored, fixed cycle counts.
  task automatic test_hs0();
    bus2.mem_ready = 1'b0;
    bus2.Zero = 1'b0; bus2.funct3 = 3'b000; bus2.funct7 = 7'b0000000;
    bus2.Op = 7'b0000011;
    @(negedge clk);
    rst2 = 1'b1;
    @(negedge clk);
    rst2 = 1'b0;
    hs0_step("hs0_lw", 4'd0); hs0_step("hs0_lw", 4'd1); hs0_step("hs0_lw", 4'd2);
    hs0_step("hs0_lw", 4'd3); hs0_step("hs0_lw", 4'd4);
    bus2.Op = 7'b0100011;
    hs0_step("hs0_sw", 4'd0); hs0_step("hs0_sw", 4'd1); hs0_step("hs0_sw", 4'd2);
    hs0_step("hs0_sw", 4'd5);
    bus2.Op = 7'b0110011;
    hs0_step("hs0_r", 4'd0); hs0_step("hs0_r", 4'd1); hs0_step("hs0_r", 4'd6);
    hs0_step("hs0_r", 4'd8);
    bus2.Op = 7'b1100011;
    hs0_step("hs0_beq", 4'd0); hs0_step("hs0_beq", 4'd1); hs0_step("hs0_beq", 4'd9);
    bus2.Op = 7'b1101111;
    hs0_step("hs0_jal", 4'd0); hs0_step("hs0_jal", 4'd1); hs0_step("hs0_jal", 4'd10);
    hs0_step("hs0_jal", 4'd8);
    #1;
    total++;
    if (bus2.state !== 4'd0 || bus2.retired !== 32'd5) begin
      bad++;
      $display("FAIL hs0_retired: state=%0d ret=%0d want 0 5", bus2.state, bus2.retired);
    end
  endtask

  // Bound on total run time.
  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

  initial begin
    rst  = 1'b1;
    rst2 = 1'b1;
    exp_ret = '0;
    bus.mem_ready = 1'b0;
    set_instr(7'b0000000, 3'b000, 7'b0000000, 1'b0);
    bus2.Op = 7'b0000011; bus2.funct3 = 3'b000; bus2.funct7 = 7'b0000000;
    bus2.Zero = 1'b0; bus2.mem_ready = 1'b0;
    test_reset();
    test_alu();
    test_lw();
    test_sw();
    test_beq();
    test_jal();
    test_illegal();
    test_wrap();
    test_reset_mid_write();
    test_hs0();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/multicycle_control_unit.md
MULTICYCLE_CONTROL_UNIT -- requirements
Module: multicycle_control_unit

Interface
REQ-001 Parameter HS_EN, default 1: 1 = FETCH/MEMREAD/MEMWRITE wait for mem_ready; 0 = mem_ready ignored, treated as 1.
REQ-002 Parameter CNT_W, default 32: width of retired-instruction counter.
REQ-003 clk  in  1  single clock; all state updates on rising edge.
REQ-004 rst  in  1  reset, synchronous, active-high.
REQ-005 Op  in  7 / funct3  in  3 / funct7  in  7  instruction fields from the instruction register.
REQ-006 Zero  in  1  ALU zero flag; mem_ready  in  1  memory access complete this cycle.
REQ-007 PCWrite, IRWrite, RegWrite, MemWrite, AdrSrc  out  1 each: datapath enables/select.
REQ-008 ResultSrc, ALUSrcA, ALUSrcB, ImmSrc  out  2 each; ALUControl  out  3.
REQ-009 illegal_op  out  1  one-cycle pulse on an unsupported opcode; state  out  4  current state; retired  out  CNT_W  instruction count.

Function
REQ-010 Moore FSM; encodings: FETCH 0, DECODE 1, MEMADR 2, MEMREAD 3, MEMWB 4, MEMWRITE 5, EXECUTER 6, EXECUTEI 7, ALUWB 8, BEQ 9, JAL 10; codes 11-15 SHALL go to FETCH next cycle with all enables 0.
REQ-011 FETCH: AdrSrc=0, ALUSrcA=00, ALUSrcB=10, ALU add, ResultSrc=10; IRWrite=PCWrite=1 only in the cycle mem_ready=1; stays in FETCH while mem_ready=0; otherwise goes to DECODE.
REQ-012 DECODE: ALUSrcA=01, ALUSrcB=01, ALU add, ImmSrc=10. Next state by Op: 0000011/0100011 -> MEMADR, 0110011 -> EXECUTER, 0010011 -> EXECUTEI, 1100011 -> BEQ, 1101111 -> JAL, other -> FETCH with illegal_op=1 that cycle.
REQ-013 MEMADR: ALUSrcA=10, ALUSrcB=01, ALU add, ImmSrc=00 (lw) / 01 (sw); Op[5]=0 -> MEMREAD, Op[5]=1 -> MEMWRITE.
REQ-014 MEMREAD: AdrSrc=1, ResultSrc=00; waits for mem_ready, then MEMWB.
REQ-015 MEMWB: ResultSrc=01, RegWrite=1 -> FETCH.
REQ-016 MEMWRITE: AdrSrc=1, ResultSrc=00, MemWrite=1 held every cycle until the mem_ready cycle (inclusive) -> FETCH.
REQ-017 EXECUTER: ALUSrcA=10, ALUSrcB=00, ALUOp=10 -> ALUWB. EXECUTEI: ALUSrcA=10, ALUSrcB=01, ImmSrc=00, ALUOp=10 -> ALUWB.
REQ-018 ALUWB: ResultSrc=00, RegWrite=1 -> FETCH.
REQ-019 BEQ: ALUSrcA=10, ALUSrcB=00, ALUOp=01, ResultSrc=00, PCWrite=Zero -> FETCH.
REQ-020 JAL: ALUSrcA=01, ALUSrcB=10, ALU add, ResultSrc=00, PCWrite=1 -> ALUWB.
REQ-021 ALU decode: ALUOp 00 -> 000 add; 01 -> 001 sub; 10 by funct3: 000 -> 001 if Op[5]&funct7[5] else 000; 010 -> 101 slt; 110 -> 011 or; 111 -> 010 and; other -> 000.
REQ-022 Unlisted outputs in any state SHALL be 0 (selects 00, enables 0).
REQ-023 retired SHALL increment by 1 on each transition into FETCH from MEMWB, MEMWRITE, ALUWB or BEQ; wraps 2^CNT_W-1 -> 0; JAL counts once via ALUWB; illegal ops not counted.
REQ-024 With HS_EN=0 every memory state SHALL take exactly one cycle: lw 5, sw 4, R/I 4, beq 3, jal 4 cycles.

Reset
REQ-025 rst=1 at a clock edge SHALL set state=FETCH, retired=0, illegal_op=0, regardless of current state, including mid-MEMWRITE.
REQ-026 While rst=1, PCWrite, IRWrite, RegWrite and MemWrite SHALL be forced 0 combinationally.
REQ-027 The first cycle after rst deasserts SHALL be FETCH with no pending write.

Verification
REQ-028 HS_EN=1, mem_ready=1, R-type add (Op=0110011, f3=000, f7=0) -> states 0,1,6,8,0; ALUControl=000 in EXECUTER; RegWrite=1 only in ALUWB; retired 0->1.
REQ-029 sub (f7=0100000) -> ALUControl=001 in EXECUTER; addi with f7[5]=1 (Op=0010011) -> ALUControl=000.
REQ-030 sw with mem_ready low 3 cycles in MEMWRITE -> MemWrite=1 for 4 consecutive cycles, then FETCH; retired +1.
REQ-031 beq with Zero=1 -> PCWrite=1 in BEQ; with Zero=0 -> PCWrite=0; both increment retired.
REQ-032 Op=1111111 in DECODE -> illegal_op pulse 1 cycle, next state FETCH, retired unchanged.
REQ-033 rst=1 asserted during MEMWRITE -> MemWrite=0 same cycle, state=0 and retired=0 next cycle; CNT_W=4 run of 16 instructions -> retired wraps to 0.
